// File: rtl/vram_arb_if.sv
// Bus bundle between the VRAM arbiter, the blitter, the video fetch path and the VRAM port.
interface vram_arb_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          video_ena_i;
  logic          blit_cycle_o;
  logic          blit_sel_i;
  logic          blit_wr_i;
  logic [AW-1:0] blit_addr_i;
  logic [DW-1:0] blit_data_i;
  logic [DW-1:0] blit_data_o;
  logic          blit_ack_o;
  logic          vgen_sel_i;
  logic [AW-1:0] vgen_addr_i;
  logic          vgen_grant_o;
  logic [DW-1:0] vgen_data_o;
  logic          vgen_ack_o;
  logic          vram_sel_o;
  logic          vram_wr_o;
  logic [AW-1:0] vram_addr_o;
  logic [DW-1:0] vram_data_o;
  logic [DW-1:0] vram_data_i;

  // Arbiter view
  modport slave (
    input  video_ena_i, blit_sel_i, blit_wr_i, blit_addr_i, blit_data_i,
           vgen_sel_i, vgen_addr_i, vram_data_i,
    output blit_cycle_o, blit_data_o, blit_ack_o, vgen_grant_o, vgen_data_o,
           vgen_ack_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o
  );

  // Requester / memory view
  modport master (
    output video_ena_i, blit_sel_i, blit_wr_i, blit_addr_i, blit_data_i,
           vgen_sel_i, vgen_addr_i, vram_data_i,
    input  blit_cycle_o, blit_data_o, blit_ack_o, vgen_grant_o, vgen_data_o,
           vgen_ack_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o
  );
endinterface

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: slot-based sharing between blitter and video fetch,
// with a tag pipeline routing read data back to the requester that issued it.
module vram_arb #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned READ_LAT = 1
) (
  input logic       clk,
  input logic       reset_i,
  vram_arb_if.slave bus
);
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TD = READ_LAT + 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOTS - 1);
  localparam logic [CW-1:0] SLOT_BLIT = CW'(SLOTS - 2);

  // One stage of the read-return pipeline; blit=0 means the read belongs to video.
  typedef struct packed {
    logic valid;
    logic blit;
  } tag_t;

  logic [CW-1:0]   slot_cnt_q, slot_cnt_d;
  logic            blit_cycle_q, blit_cycle_d;
  logic            blit_own_q, blit_own_d;
  logic            vram_sel_q, vram_sel_d;
  logic            vram_wr_q, vram_wr_d;
  logic [AW-1:0]   vram_addr_q, vram_addr_d;
  logic [DW-1:0]   vram_wdata_q, vram_wdata_d;
  tag_t [TD-1:0]   tag_q, tag_d;
  tag_t            tag_new;
  logic [DW-1:0]   blit_rdata_q, blit_rdata_d;
  logic            blit_ack_q, blit_ack_d;
  logic [DW-1:0]   vgen_rdata_q, vgen_rdata_d;
  logic            vgen_ack_q, vgen_ack_d;
  logic            vgen_grant_c;

  // Video wins every slot the blitter does not own; nothing is granted while in reset.
  assign vgen_grant_c = reset_i & ~blit_own_q & bus.vgen_sel_i;

  // Slot schedule, port mux and read-return steering.
  always_comb begin
    slot_cnt_d   = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + CW'(1);
    blit_cycle_d = ~bus.video_ena_i | (slot_cnt_q == SLOT_BLIT);
    blit_own_d   = blit_cycle_q;

    vram_sel_d   = 1'b0;
    vram_wr_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;

    if (blit_own_q) begin
      if (bus.blit_sel_i) begin
        vram_sel_d   = 1'b1;
        vram_wr_d    = bus.blit_wr_i;
        vram_addr_d  = bus.blit_addr_i;
        vram_wdata_d = bus.blit_data_i;
      end
    end else if (vgen_grant_c) begin
      vram_sel_d  = 1'b1;
      vram_addr_d = bus.vgen_addr_i;
    end

    // Only reads need a return path; the owner is whoever held this slot.
    tag_new.valid = vram_sel_d & ~vram_wr_d;
    tag_new.blit  = blit_own_q;
    tag_d         = {tag_q[TD-2:0], tag_new};

    blit_ack_d   = 1'b0;
    blit_rdata_d = blit_rdata_q;
    vgen_ack_d   = 1'b0;
    vgen_rdata_d = vgen_rdata_q;
    if (tag_q[TD-1].valid) begin
      if (tag_q[TD-1].blit) begin
        blit_ack_d   = 1'b1;
        blit_rdata_d = bus.vram_data_i;
      end else begin
        vgen_ack_d   = 1'b1;
        vgen_rdata_d = bus.vram_data_i;
      end
    end
  end

  // State and output registers; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      slot_cnt_q   <= '0;
      blit_cycle_q <= 1'b0;
      blit_own_q   <= 1'b0;
      vram_sel_q   <= 1'b0;
      vram_wr_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      tag_q        <= '0;
      blit_rdata_q <= '0;
      blit_ack_q   <= 1'b0;
      vgen_rdata_q <= '0;
      vgen_ack_q   <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      blit_cycle_q <= blit_cycle_d;
      blit_own_q   <= blit_own_d;
      vram_sel_q   <= vram_sel_d;
      vram_wr_q    <= vram_wr_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      tag_q        <= tag_d;
      blit_rdata_q <= blit_rdata_d;
      blit_ack_q   <= blit_ack_d;
      vgen_rdata_q <= vgen_rdata_d;
      vgen_ack_q   <= vgen_ack_d;
    end
  end

  assign bus.blit_cycle_o = blit_cycle_q;
  assign bus.blit_data_o  = blit_rdata_q;
  assign bus.blit_ack_o   = blit_ack_q;
  assign bus.vgen_grant_o = vgen_grant_c;
  assign bus.vgen_data_o  = vgen_rdata_q;
  assign bus.vgen_ack_o   = vgen_ack_q;
  assign bus.vram_sel_o   = vram_sel_q;
  assign bus.vram_wr_o    = vram_wr_q;
  assign bus.vram_addr_o  = vram_addr_q;
  assign bus.vram_data_o  = vram_wdata_q;
endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb with SLOTS=4, READ_LAT=2.
module tb_vram_arb;
  localparam int unsigned S  = 4;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vram_arb_if bus();

  vram_arb #(.SLOTS(S), .READ_LAT(RL)) dut (
    .clk    (clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  // VRAM behavioural model: data shows up RL cycles after the address is presented.
  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  logic [15:0] vmem [0:65535];
  logic [15:0] dpipe [RL];
  logic        mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) vmem[a] <= mem_init(16'(a));
      mem_ready <= 1'b1;
    end else if (bus.vram_sel_o && bus.vram_wr_o) begin
      vmem[bus.vram_addr_o] <= bus.vram_data_o;
    end
    dpipe[0] <= vmem[bus.vram_addr_o];
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.vram_data_i = dpipe[RL-1];

  // Scoreboard state
  typedef struct {
    logic        sel;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        full;
  } acc_t;
  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  acc_t        acc_q [$];
  ret_t        bret_q [$];
  ret_t        vret_q [$];
  logic [15:0] refm [logic [15:0]];

  int          cyc;
  int          n_tests;
  int          n_fail;
  logic        m_bc, m_own;
  int          m_slot;
  logic [15:0] m_bdata, m_vdata;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return refm.exists(a) ? refm[a] : mem_init(a);
  endfunction

  // One clock cycle: drive inputs, predict, advance, then compare everything visible.
  task automatic step(input logic rst, input logic bsel, input logic bwr,
                      input logic [15:0] baddr, input logic [15:0] bdata,
                      input logic vsel, input logic [15:0] vaddr);
    acc_t e;
    ret_t r;
    logic ven_s;
    logic exp_ack;
    rst_n           = rst;
    bus.blit_sel_i  = bsel;
    bus.blit_wr_i   = bwr;
    bus.blit_addr_i = baddr;
    bus.blit_data_i = bdata;
    bus.vgen_sel_i  = vsel;
    bus.vgen_addr_i = vaddr;
    ven_s           = bus.video_ena_i;
    #1;
    chk("vgen_grant", 16'(bus.vgen_grant_o), 16'(rst & vsel & ~m_own));

    e.sel = 1'b0; e.wr = 1'b0; e.addr = '0; e.data = '0; e.full = ~rst;
    if (rst) begin
      if (m_own && bsel) begin
        e.sel = 1'b1; e.wr = bwr; e.addr = baddr; e.data = bdata;
        if (bwr) refm[baddr] = bdata;
        else begin
          r.due = cyc + 2 + RL; r.data = ref_rd(baddr);
          bret_q.push_back(r);
        end
      end else if (!m_own && vsel) begin
        e.sel = 1'b1; e.addr = vaddr;
        r.due = cyc + 2 + RL; r.data = ref_rd(vaddr);
        vret_q.push_back(r);
      end
    end
    acc_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      m_slot = 0; m_bc = 1'b0; m_own = 1'b0;
      m_bdata = '0; m_vdata = '0;
      bret_q.delete();
      vret_q.delete();
    end else begin
      m_own  = m_bc;
      m_bc   = ~ven_s | (m_slot == int'(S) - 2);
      m_slot = (m_slot == int'(S) - 1) ? 0 : m_slot + 1;
    end

    e = acc_q.pop_front();
    chk("vram_sel", 16'(bus.vram_sel_o), 16'(e.sel));
    chk("vram_wr", 16'(bus.vram_wr_o), 16'(e.wr));
    if (e.sel || e.full) chk("vram_addr", bus.vram_addr_o, e.addr);
    if ((e.sel && e.wr) || e.full) chk("vram_data", bus.vram_data_o, e.data);
    chk("blit_cycle", 16'(bus.blit_cycle_o), 16'(m_bc));

    exp_ack = 1'b0;
    if (bret_q.size() > 0 && bret_q[0].due == cyc) begin
      r = bret_q.pop_front(); m_bdata = r.data; exp_ack = 1'b1;
    end
    chk("blit_ack", 16'(bus.blit_ack_o), 16'(exp_ack));
    chk("blit_data", bus.blit_data_o, m_bdata);

    exp_ack = 1'b0;
    if (vret_q.size() > 0 && vret_q[0].due == cyc) begin
      r = vret_q.pop_front(); m_vdata = r.data; exp_ack = 1'b1;
    end
    chk("vgen_ack", 16'(bus.vgen_ack_o), 16'(exp_ack));
    chk("vgen_data", bus.vgen_data_o, m_vdata);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [15:0] va;
    logic        g;
    logic        done;
    cyc = 0; n_tests = 0; n_fail = 0;
    m_bc = 1'b0; m_own = 1'b0; m_slot = 0; m_bdata = '0; m_vdata = '0;
    bus.video_ena_i = 1'b1;

    // Reset held 3 cycles, then watch the blit_cycle cadence with video on
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (12) idle();

    // Video off: blitter owns every slot, 16 back-to-back writes
    bus.video_ena_i = 1'b0;
    repeat (2) idle();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'b1, 16'(32'hFFFF - i), 16'h1F20, 1'b0, '0);
    repeat (4) idle();

    // Video on: held video request with incrementing addresses
    bus.video_ena_i = 1'b1;
    va = 16'h0100;
    for (int i = 0; i < 16; i++) begin
      g = ~m_own;
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, va);
      if (g) va++;
    end
    repeat (6) idle();

    // Blitter read of 0x1234 interleaved with video reads
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (m_own && !done) begin
        step(1'b1, 1'b1, 1'b0, 16'h1234, '0, 1'b1, va);
        done = 1'b1;
      end else begin
        g = ~m_own;
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, va);
        if (g) va++;
      end
    end
    repeat (6) idle();

    // Reset while two video reads are in flight
    for (int i = 0; i < int'(S) && !m_own; i++) idle();
    idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 16'h2000);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 16'h2001);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (8) idle();

    // Blitter request on a slot it does not own, with a concurrent video request
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(S) && m_own; i++) idle();
      step(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'(32'h3000 + k));
      idle();
    end
    repeat (8) idle();

    chk("blit_ret_left", 16'(bret_q.size()), 16'd0);
    chk("vgen_ret_left", 16'(vret_q.size()), 16'd0);
    chk("aaaa_untouched", vmem[16'hAAAA], mem_init(16'hAAAA));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
